seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 144 ++++++++++++++
 tb/tb_seg_scan_decoder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed two-digit active-low 7-segment scan bus into a 4-bit value.
// Each digit is captured once it has been stable for STABLE_CYCLES samples.
module seg_scan_decoder #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] seg,
   input  logic [1:0] an,
   output logic [3:0] value,
   output logic       value_valid,
   output logic       err
);

   typedef enum logic [1:0] {StWaitAny, StHaveTens, StHaveUnits} state_e;

   localparam logic [3:0] RunMax     = 4'(STABLE_CYCLES);
   localparam logic [8:0] SampleIdle = {2'b11, 7'b1111111};

   logic [8:0] sample_q, prev_q;
   logic [3:0] run_q, run_d;
   state_e     state_q, state_d;
   logic [3:0] tens_q, tens_d;
   logic [3:0] units_q, units_d;
   logic [3:0] value_q, value_d;
   logic       valid_q, valid_d;
   logic       err_q, err_d;

   logic       sel_one, is_tens, conflict_first, capture;
   logic [3:0] dig;
   logic       dig_ok;
   logic [3:0] pair_tens, pair_units;
   logic [6:0] pair_sum;

   assign sel_one        = sample_q[8] ^ sample_q[7];
   assign is_tens        = (sample_q[8:7] == 2'b01);
   assign conflict_first = (sample_q[8:7] == 2'b00) && (prev_q[8:7] != 2'b00);

   always_comb begin
      run_d = 4'd0;
      if (!sel_one) begin
         run_d = 4'd0;
      end else if (sample_q != prev_q) begin
         run_d = 4'd1;
      end else if (run_q == RunMax) begin
         run_d = RunMax;
      end else begin
         run_d = run_q + 4'd1;
      end
   end

   // Fire only on the cycle the counter first reaches the threshold.
   assign capture = (run_d == RunMax) && (run_q != RunMax);

   always_comb begin
      dig    = 4'd0;
      dig_ok = 1'b1;
      case (sample_q[6:0])
         7'b1000000: dig = 4'd0;
         7'b1111001: dig = 4'd1;
         7'b0100100: dig = 4'd2;
         7'b0110000: dig = 4'd3;
         7'b0011001: dig = 4'd4;
         7'b0010010: dig = 4'd5;
         7'b0000010: dig = 4'd6;
         7'b1111000: dig = 4'd7;
         7'b0000000: dig = 4'd8;
         7'b0010000: dig = 4'd9;
         default:    dig_ok = 1'b0;
      endcase
   end

   assign pair_tens  = is_tens ? dig : tens_q;
   assign pair_units = is_tens ? units_q : dig;
   assign pair_sum   = {3'b000, pair_tens} * 7'd10 + {3'b000, pair_units};

   always_comb begin
      state_d = state_q;
      tens_d  = tens_q;
      units_d = units_q;
      value_d = value_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      if (conflict_first) begin
         err_d   = 1'b1;
         state_d = StWaitAny;
         tens_d  = 4'd0;
         units_d = 4'd0;
      end else if (capture) begin
         if (!dig_ok) begin
            err_d   = 1'b1;
            state_d = StWaitAny;
            tens_d  = 4'd0;
            units_d = 4'd0;
         end else if ((is_tens && state_q == StHaveUnits) ||
                      (!is_tens && state_q == StHaveTens)) begin
            if (pair_sum <= 7'd15) begin
               value_d = pair_sum[3:0];
               valid_d = 1'b1;
            end else begin
               err_d = 1'b1;
            end
            state_d = StWaitAny;
            tens_d  = 4'd0;
            units_d = 4'd0;
         end else if (is_tens) begin
            tens_d  = dig;
            state_d = StHaveTens;
         end else begin
            units_d = dig;
            state_d = StHaveUnits;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sample_q <= SampleIdle;
         prev_q   <= SampleIdle;
         run_q    <= 4'd0;
         state_q  <= StWaitAny;
         tens_q   <= 4'd0;
         units_q  <= 4'd0;
         value_q  <= 4'd0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         sample_q <= {an, seg};
         prev_q   <= sample_q;
         run_q    <= run_d;
         state_q  <= state_d;
         tens_q   <= tens_d;
         units_q  <= units_d;
         value_q  <= value_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   assign value       = value_q;
   assign value_valid = valid_q;
   assign err         = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios then random scan traffic,
// compared every cycle against a history-based reference model.
module tb_seg_scan_decoder;

   localparam int unsigned S = 4;
   localparam logic [8:0] Idle = {2'b11, 7'b1111111};

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] seg;
   logic [1:0] an;
   logic [3:0] value;
   logic       value_valid;
   logic       err;

   always #5 clk = ~clk;

   seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .seg        (seg),
      .an         (an),
      .value      (value),
      .value_valid(value_valid),
      .err        (err)
   );

   logic [6:0] pats [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   // hist[0] is the oldest sample, hist[S] the sample taken at the previous edge.
   logic [8:0] hist [$];
   int         n_cmp, n_fail;
   int         m_tens, m_units;
   int         m_value;
   logic       m_valid, m_err;

   function automatic int decode(input logic [6:0] p);
      for (int i = 0; i < 10; i++) if (p == pats[i]) return i;
      return -1;
   endfunction

   task automatic complete(input int t, input int u);
      int r;
      r = t * 10 + u;
      if (r <= 15) begin
         m_value = r;
         m_valid = 1'b1;
      end else begin
         m_err = 1'b1;
      end
      m_tens  = -1;
      m_units = -1;
   endtask

   task automatic model_edge(input logic rst, input logic [8:0] x);
      logic stable;
      logic [8:0] cur;
      int d;
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (!rst) begin
         m_value = 0;
         m_tens  = -1;
         m_units = -1;
         void'(hist.pop_front());
         hist.push_back(Idle);
         return;
      end
      cur = hist[S];
      stable = (hist[0] != hist[1]);
      for (int i = 1; i < S; i++) if (hist[i] != hist[i+1]) stable = 1'b0;
      if (cur[8:7] == 2'b00 && hist[S-1][8:7] != 2'b00) begin
         m_err   = 1'b1;
         m_tens  = -1;
         m_units = -1;
      end else if ((cur[8:7] == 2'b01 || cur[8:7] == 2'b10) && stable) begin
         d = decode(cur[6:0]);
         if (d < 0) begin
            m_err   = 1'b1;
            m_tens  = -1;
            m_units = -1;
         end else if (cur[8:7] == 2'b01) begin
            if (m_units >= 0) complete(d, m_units);
            else m_tens = d;
         end else begin
            if (m_tens >= 0) complete(m_tens, d);
            else m_units = d;
         end
      end
      void'(hist.pop_front());
      hist.push_back(x);
   endtask

   task automatic check();
      n_cmp++;
      assert (value === 4'(m_value)) else begin
         n_fail++;
         $error("FAIL value: got %0d expected %0d", value, m_value);
      end
      n_cmp++;
      assert (value_valid === m_valid) else begin
         n_fail++;
         $error("FAIL value_valid: got %b expected %b", value_valid, m_valid);
      end
      n_cmp++;
      assert (err === m_err) else begin
         n_fail++;
         $error("FAIL err: got %b expected %b", err, m_err);
      end
   endtask

   task automatic step(input logic rst, input logic [1:0] a, input logic [6:0] s);
      rst_n = rst;
      an    = a;
      seg   = s;
      @(posedge clk);
      model_edge(rst, {a, s});
      #1;
      check();
   endtask

   task automatic hold(input logic [1:0] a, input logic [6:0] s, input int n);
      for (int i = 0; i < n; i++) step(1'b1, a, s);
   endtask

   initial begin
      int nseg, pick;
      logic [1:0] ra;
      logic [6:0] rs;
      n_cmp   = 0;
      n_fail  = 0;
      m_value = 0;
      m_tens  = -1;
      m_units = -1;
      for (int i = 0; i <= S; i++) hist.push_back(Idle);
      rst_n = 1'b0;
      an    = 2'b11;
      seg   = 7'h7F;

      step(1'b0, 2'b11, 7'h7F);
      step(1'b0, 2'b11, 7'h7F);

      // 0 then 3 -> 3
      hold(2'b01, 7'b1000000, 6);
      hold(2'b10, 7'b0110000, 6);
      hold(2'b11, 7'h7F, 2);
      // 1 then 5 -> 15
      hold(2'b01, 7'b1111001, 6);
      hold(2'b10, 7'b0010010, 6);
      hold(2'b11, 7'h7F, 2);
      // 1 then 6 -> 16 overflow
      hold(2'b01, 7'b1111001, 6);
      hold(2'b10, 7'b0000010, 6);
      hold(2'b11, 7'h7F, 2);
      // too short to capture
      hold(2'b10, 7'b0110000, 3);
      hold(2'b11, 7'h7F, 6);
      // invalid pattern, then a long conflict
      hold(2'b10, 7'b0001000, 6);
      hold(2'b11, 7'h7F, 2);
      hold(2'b00, 7'b0110000, 5);
      hold(2'b11, 7'h7F, 2);
      // reset between tens and units
      hold(2'b01, 7'b1000000, 6);
      step(1'b0, 2'b01, 7'b1000000);
      hold(2'b10, 7'b0110000, 6);
      hold(2'b11, 7'h7F, 2);
      // units first, then tens overwrite order
      hold(2'b10, 7'b0100100, 6);
      hold(2'b01, 7'b1111001, 6);
      hold(2'b11, 7'h7F, 2);

      nseg = 250;
      for (int k = 0; k < nseg; k++) begin
         pick = $urandom_range(0, 9);
         ra   = (pick < 4) ? 2'b01 : (pick < 8) ? 2'b10 : (pick == 8) ? 2'b11 : 2'b00;
         if ($urandom_range(0, 4) == 0) rs = 7'($urandom_range(0, 127));
         else rs = pats[(ra == 2'b01) ? $urandom_range(0, 1) : $urandom_range(0, 9)];
         if ($urandom_range(0, 40) == 0) step(1'b0, ra, rs);
         else hold(ra, rs, $urandom_range(1, 8));
      end
      hold(2'b11, 7'h7F, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
